// File: rtl/zoran_nios_cpu_cpu_debug_mem_ctrl.sv
// rtl/zoran_nios_cpu_cpu_debug_mem_ctrl.sv - debug-RAM access sequencer driven by JTAG debug-slave strobes
module zoran_nios_cpu_cpu_debug_mem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic              mem_waitrequest,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [31:0]       MonDReg,
  output logic              busy,
  output logic              cmd_dropped
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_REQ  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_WR_REQ  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              dropped_q, dropped_d;
  logic              any_strobe;

  // Only the address field, the read flag and the write-data field of jdo matter here.
  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Next-state decode: commands are accepted only in IDLE; everything else is dropped.
  always_comb begin
    state_d   = state_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    wdata_d   = wdata_q;
    dropped_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a) begin
          mon_a_d   = jdo[17+ADDR_W-1:17];
          dropped_d = take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[35]) state_d = S_RD_REQ;
        end else if (take_action_ocimem_b) begin
          wdata_d   = jdo[34:3];
          mon_d_d   = jdo[34:3];
          dropped_d = take_no_action_ocimem_a;
          state_d   = S_WR_REQ;
        end else if (take_no_action_ocimem_a) begin
          if (jdo[35]) state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        dropped_d = any_strobe;
        if (!mem_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Data is only taken here, so a valid strobe is never earlier than one cycle after acceptance.
        dropped_d = any_strobe;
        if (mem_readdatavalid) begin
          mon_d_d = mem_readdata;
          mon_a_d = mon_a_q + ADDR_ONE;
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        dropped_d = any_strobe;
        if (!mem_waitrequest) begin
          mon_a_d = mon_a_q + ADDR_ONE;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      wdata_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      wdata_q   <= wdata_d;
      dropped_q <= dropped_d;
    end
  end

  // Requests come straight from the registered state so address/data stay put while stalled.
  assign mem_read      = (state_q == S_RD_REQ);
  assign mem_write     = (state_q == S_WR_REQ);
  assign mem_address   = mon_a_q;
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_d_q;
  assign busy          = (state_q != S_IDLE);
  assign cmd_dropped   = dropped_q;

endmodule
